// File: rtl/spi_pkg.sv
// Shared definitions for the SPI slave receiver: word length default,
// synchronizer depth and the receiver state encoding.
package spi_pkg;

  localparam int DATA_LEN_DEF = 32;
  localparam int SYNC_DEPTH   = 3;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/spi_input_sync.sv
// Multi-stage synchronizer for one asynchronous SPI line, with rise/fall
// detection taken from the two oldest stages.
module spi_input_sync
  import spi_pkg::*;
#(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic i_async,
  output logic o_sync,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_DEPTH-1:0] r_sync;

  // Shift the asynchronous input through the synchronizer chain.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= {SYNC_DEPTH{RST_VAL}};
    end else begin
      r_sync <= {r_sync[SYNC_DEPTH-2:0], i_async};
    end
  end

  assign o_sync = r_sync[SYNC_DEPTH-2];
  assign o_rise = r_sync[SYNC_DEPTH-2] & ~r_sync[SYNC_DEPTH-1];
  assign o_fall = ~r_sync[SYNC_DEPTH-2] & r_sync[SYNC_DEPTH-1];

endmodule

// File: rtl/spi_slave_receiver.sv
// SPI mode-0 slave receiver with valid/ready output, sticky overrun and
// frame-error pulse. Define SPI_RX_MSB_FIRST_EN for MSB-first shifting.
module spi_slave_receiver
  import spi_pkg::*;
#(
  parameter int DATA_LEN = DATA_LEN_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sck,
  input  logic                ssel,
  input  logic                mosi,
  output logic [DATA_LEN-1:0] data,
  output logic                valid,
  input  logic                ready,
  output logic                overrun,
  output logic                frame_err
);

  localparam int            CW       = $clog2(DATA_LEN);
  localparam logic [CW-1:0] CNT_LAST = CW'(DATA_LEN - 1);

  logic          w_sck_rise;
  logic          w_ssel_rise;
  logic          w_ssel_fall;
  logic          w_mosi;
  state_t        r_state;
  state_t        w_state_next;
  logic          w_start;
  logic          w_abort;
  logic          w_shift;
  logic          w_word_done;
  logic [CW-1:0] r_cnt;
  logic [DATA_LEN-1:0] r_shreg;
  logic [DATA_LEN-1:0] w_shreg_next;
  logic [DATA_LEN-1:0] r_data;
  logic          r_valid;
  logic          r_overrun;
  logic          r_frame_err;

  spi_input_sync #(.RST_VAL(1'b0)) u_sync_sck (
    .clk(clk), .rst(rst), .i_async(sck),
    .o_sync(), .o_rise(w_sck_rise), .o_fall()
  );

  spi_input_sync #(.RST_VAL(1'b1)) u_sync_ssel (
    .clk(clk), .rst(rst), .i_async(ssel),
    .o_sync(), .o_rise(w_ssel_rise), .o_fall(w_ssel_fall)
  );

  spi_input_sync #(.RST_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .rst(rst), .i_async(mosi),
    .o_sync(w_mosi), .o_rise(), .o_fall()
  );

`ifdef SPI_RX_MSB_FIRST_EN
  assign w_shreg_next = {r_shreg[DATA_LEN-2:0], w_mosi};
`else
  assign w_shreg_next = {w_mosi, r_shreg[DATA_LEN-1:1]};
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and control strobes; a ssel rise masks a coincident sck rise.
  always_comb begin
    w_state_next = r_state;
    w_start      = 1'b0;
    w_abort      = 1'b0;
    w_shift      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_ssel_fall) begin
          w_state_next = ST_SHIFT;
          w_start      = 1'b1;
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (w_ssel_rise) begin
          w_state_next = ST_IDLE;
          w_abort      = (r_cnt != {CW{1'b0}});
        end else if (w_sck_rise) begin
          w_shift = 1'b1;
        end else begin
          w_state_next = ST_SHIFT;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
    w_word_done = w_shift & (r_cnt == CNT_LAST);
  end

  // Datapath: shifting, word hand-off, overrun and frame-error tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt       <= {CW{1'b0}};
      r_shreg     <= {DATA_LEN{1'b0}};
      r_data      <= {DATA_LEN{1'b0}};
      r_valid     <= 1'b0;
      r_overrun   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_frame_err <= w_abort;
      if (w_start) begin
        r_cnt   <= {CW{1'b0}};
        r_shreg <= {DATA_LEN{1'b0}};
      end else if (w_shift) begin
        r_shreg <= w_shreg_next;
        r_cnt   <= w_word_done ? {CW{1'b0}} : r_cnt + CW'(1);
      end
      // A finished word only replaces data once the previous one is taken.
      if (w_word_done && (!r_valid || ready)) begin
        r_data  <= w_shreg_next;
        r_valid <= 1'b1;
      end else if (r_valid && ready) begin
        r_valid <= 1'b0;
      end
      if (w_ssel_fall) begin
        r_overrun <= 1'b0;
      end else if (w_word_done && r_valid && !ready) begin
        r_overrun <= 1'b1;
      end
    end
  end

  assign data      = r_data;
  assign valid     = r_valid;
  assign overrun   = r_overrun;
  assign frame_err = r_frame_err;

endmodule

// File: tb/tb_spi_slave_receiver.sv
// Directed self-checking bench for spi_slave_receiver; bit order follows
// SPI_RX_MSB_FIRST_EN the same way as the design.
module tb_spi_slave_receiver;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sck = 1'b0;
  logic        ssel = 1'b1;
  logic        mosi = 1'b0;
  logic [31:0] data;
  logic        valid;
  logic        ready = 1'b1;
  logic        overrun;
  logic        frame_err;

  int checks = 0;
  int failures = 0;
  int valid_cycles = 0;
  int ferr_pulses = 0;
  int ovr_cycles = 0;
  logic [31:0] last_data = 32'h0;

  spi_slave_receiver #(.DATA_LEN(32)) dut (
    .clk(clk), .rst(rst), .sck(sck), .ssel(ssel), .mosi(mosi),
    .data(data), .valid(valid), .ready(ready),
    .overrun(overrun), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  // Observe outputs away from the active edge.
  always @(negedge clk) begin
    if (valid) begin
      valid_cycles = valid_cycles + 1;
      last_data    = data;
    end
    if (frame_err) ferr_pulses = ferr_pulses + 1;
    if (overrun) ovr_cycles = ovr_cycles + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      failures = failures + 1;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic clr_mon();
    valid_cycles = 0;
    ferr_pulses  = 0;
    ovr_cycles   = 0;
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    mosi = b;
    wait_clk(4);
    sck = 1'b1;
    wait_clk(4);
    sck = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 32; i++) begin
`ifdef SPI_RX_MSB_FIRST_EN
      send_bit(w[31-i]);
`else
      send_bit(w[i]);
`endif
    end
  endtask

  task automatic sel_low();
    ssel = 1'b0;
    wait_clk(6);
  endtask

  task automatic sel_high();
    wait_clk(4);
    ssel = 1'b1;
    wait_clk(8);
  endtask

  initial begin
    #1ms;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] sw;
    wait_clk(4);
    rst = 1'b0;
    wait_clk(2);
    check_eq("rst_valid", {31'h0, valid}, 32'h0);
    check_eq("rst_data", data, 32'h0);
    check_eq("rst_overrun", {31'h0, overrun}, 32'h0);
    check_eq("rst_frame_err", {31'h0, frame_err}, 32'h0);

    // Single word, consumer always ready.
    clr_mon();
    ready = 1'b1;
    sel_low();
    send_word(32'h87654321);
    sel_high();
    check_eq("w1_valid_cycles", valid_cycles, 32'd1);
    check_eq("w1_data", last_data, 32'h87654321);
    check_eq("w1_overrun", ovr_cycles, 32'd0);
    check_eq("w1_frame_err", ferr_pulses, 32'd0);
    check_eq("w1_valid_end", {31'h0, valid}, 32'h0);

    // Two words back-to-back with consumer stalled: overrun.
    clr_mon();
    ready = 1'b0;
    sel_low();
    send_word(32'hDEADBEEF);
    send_word(32'h00000001);
    sel_high();
    check_eq("ovr_data", data, 32'hDEADBEEF);
    check_eq("ovr_valid", {31'h0, valid}, 32'h1);
    check_eq("ovr_overrun", {31'h0, overrun}, 32'h1);
    sel_low();
    check_eq("ovr_clear", {31'h0, overrun}, 32'h0);
    check_eq("ovr_data_kept", data, 32'hDEADBEEF);
    ready = 1'b1;
    wait_clk(2);
    check_eq("ovr_consumed", {31'h0, valid}, 32'h0);
    sel_high();
    check_eq("ovr_no_ferr", ferr_pulses, 32'd0);

    // Two words back-to-back, consumer ready: both delivered.
    clr_mon();
    sel_low();
    send_word(32'h0F0F1234);
    check_eq("b2b_first", last_data, 32'h0F0F1234);
    send_word(32'h80000003);
    sel_high();
    check_eq("b2b_second", last_data, 32'h80000003);
    check_eq("b2b_valid_cycles", valid_cycles, 32'd2);
    check_eq("b2b_overrun", ovr_cycles, 32'd0);

    // Frame aborted after 13 bits.
    clr_mon();
    sw = 32'h00001ABC;
    sel_low();
    for (int i = 0; i < 13; i++) send_bit(sw[i]);
    sel_high();
    check_eq("abort_ferr", ferr_pulses, 32'd1);
    check_eq("abort_valid", valid_cycles, 32'd0);
    clr_mon();
    sel_low();
    send_word(32'hA5A5A5A5);
    sel_high();
    check_eq("after_abort_data", last_data, 32'hA5A5A5A5);
    check_eq("after_abort_valid", valid_cycles, 32'd1);
    check_eq("after_abort_ferr", ferr_pulses, 32'd0);

    // Reset in the middle of a frame.
    sw = 32'hFFFFFFFF;
    sel_low();
    for (int i = 0; i < 20; i++) send_bit(sw[i]);
    rst = 1'b1;
    ssel = 1'b1;
    wait_clk(4);
    rst = 1'b0;
    wait_clk(4);
    check_eq("midrst_data", data, 32'h0);
    check_eq("midrst_valid", {31'h0, valid}, 32'h0);
    clr_mon();
    sel_low();
    send_word(32'h12345678);
    sel_high();
    check_eq("midrst_new_data", last_data, 32'h12345678);
    check_eq("midrst_ferr", ferr_pulses, 32'd0);

`ifdef SPI_RX_MSB_FIRST_EN
    clr_mon();
    sel_low();
    send_word(32'hCAFEF00D);
    sel_high();
    check_eq("msb_data", last_data, 32'hCAFEF00D);
`endif

    // sck activity while deselected is ignored.
    clr_mon();
    for (int i = 0; i < 40; i++) send_bit(1'(i % 3));
    wait_clk(8);
    check_eq("idle_valid", valid_cycles, 32'd0);
    check_eq("idle_ferr", ferr_pulses, 32'd0);
    check_eq("idle_overrun", ovr_cycles, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
